sqrt_result_display: RTL and testbench

//  Downstream consumer of the square-root pipeline.
//  - Tracks which pipeline slots carry a real sample, using a valid shift register as deep as the pipeline.
//  - Captures each finished 4-bit root into a holding register and drives it to a hex seven-segment digit.
//  - Lights the decimal point for a programmable time after every new result, marking a fresh value.

---
 rtl/sqrt_result_display.sv | 117 +++++++++++
 tb/tb_sqrt_result_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_result_display.sv
// Display stage for the square-root pipeline: tracks in-flight samples, latches each
// finished root, drives a hex seven-segment digit and flags fresh results on the decimal point.
module sqrt_result_display #(
  parameter int LATENCY     = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] sqrt_q,
  output logic [3:0] result,
  output logic       out_valid,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, STEADY} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [LATENCY-1:0] vld_sr;
  logic               capture;

  assign capture = vld_sr[LATENCY-1];

  // One valid bit per pipeline slot, so a sample's root is taken exactly when it emerges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= capture;
      if (capture) result <= sqrt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A new capture always restarts the freshness window, even on the edge it would expire.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (capture) begin
          state_next = SHOW;
          cnt_next   = CNT_LOAD;
        end
      end
      SHOW: begin
        if (capture) begin
          cnt_next = CNT_LOAD;
        end else if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          state_next = STEADY;
        end
      end
      STEADY: begin
        if (capture) begin
          state_next = SHOW;
          cnt_next   = CNT_LOAD;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    dp  = (state == SHOW);
    seg = 7'h00;
    if (state != IDLE) begin
      case (result)
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        default: seg = 7'h71;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_result_display.sv
// Scoreboard bench for sqrt_result_display: expected captures are queued at issue time and
// popped by a monitor on every out_valid pulse; dp timing is checked per cycle.
module tb_sqrt_result_display;

  localparam logic [3:0] JUNK = 4'hE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_valid_b;
  logic [3:0] sqrt_q, sqrt_q_b;
  logic [3:0] result, result_b;
  logic       out_valid, out_valid_b;
  logic [6:0] seg, seg_b;
  logic       dp, dp_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] exp_q[$];

  sqrt_result_display #(.LATENCY(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sqrt_q(sqrt_q),
    .result(result), .out_valid(out_valid), .seg(seg), .dp(dp)
  );

  sqrt_result_display #(.LATENCY(1), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .sqrt_q(sqrt_q_b),
    .result(result_b), .out_valid(out_valid_b), .seg(seg_b), .dp(dp_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
  endtask

  task automatic expectCapture(input logic [3:0] root, input logic [6:0] segv);
    exp_q.push_back({root, segv});
  endtask

  // One clock edge: drive inputs at the falling edge, check dp in the cycle after the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] q, input logic exp_dp);
    in_valid = v;
    sqrt_q   = q;
    @(posedge clk);
    @(negedge clk);
    checkOutput("dp", {7'd0, dp}, {7'd0, exp_dp});
  endtask

  task automatic idleCycles(input int n, input logic exp_dp);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, JUNK, exp_dp);
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 8'd1, 8'd0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        checkOutput("result", {4'd0, result}, {4'd0, e[10:7]});
        checkOutput("seg", {1'b0, seg}, {1'b0, e[6:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; sqrt_q = 4'h7;
    in_valid_b = 1'b0; sqrt_q_b = JUNK;

    // Test 1: reset state, in_valid ignored while in reset, then idle
    repeat (3) @(negedge clk);
    checkOutput("rst_result", {4'd0, result}, 8'h00);
    checkOutput("rst_out_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("rst_seg", {1'b0, seg}, 8'h00);
    checkOutput("rst_dp", {7'd0, dp}, 8'h00);
    checkOutput("rst_seg_b", {1'b0, seg_b}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, JUNK, 1'b0);
      checkOutput("idle_seg", {1'b0, seg}, 8'h00);
      checkOutput("idle_result", {4'd0, result}, 8'h00);
      checkOutput("idle_out_valid", {7'd0, out_valid}, 8'h00);
    end

    // Test 2: single sample, root 9
    expectCapture(4'h9, 7'h6F);
    applyStimulus(1'b1, JUNK, 1'b0);
    idleCycles(3, 1'b0);
    applyStimulus(1'b0, 4'h9, 1'b1);
    idleCycles(3, 1'b1);
    idleCycles(2, 1'b0);
    checkOutput("steady_seg", {1'b0, seg}, 8'h6F);
    checkOutput("steady_result", {4'd0, result}, 8'h09);

    // Test 3: back-to-back samples 3, 7, 11
    expectCapture(4'h3, 7'h4F);
    expectCapture(4'h7, 7'h07);
    expectCapture(4'hB, 7'h7C);
    applyStimulus(1'b1, JUNK, 1'b0);
    applyStimulus(1'b1, JUNK, 1'b0);
    applyStimulus(1'b1, JUNK, 1'b0);
    applyStimulus(1'b0, JUNK, 1'b0);
    applyStimulus(1'b0, 4'h3, 1'b1);
    applyStimulus(1'b0, 4'h7, 1'b1);
    applyStimulus(1'b0, 4'hB, 1'b1);
    idleCycles(3, 1'b1);
    idleCycles(1, 1'b0);
    checkOutput("t3_seg", {1'b0, seg}, 8'h7C);

    // Test 4a: captures at edges 4 and 7, dp high 4..10
    expectCapture(4'h2, 7'h5B);
    expectCapture(4'h4, 7'h66);
    applyStimulus(1'b1, JUNK, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, JUNK, 1'b0);
    applyStimulus(1'b0, 4'h2, 1'b1);
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 4'h4, 1'b1);
    idleCycles(3, 1'b1);
    idleCycles(1, 1'b0);

    // Test 4b: second capture exactly on the expiry edge (8), dp high 4..11
    expectCapture(4'h1, 7'h06);
    expectCapture(4'h8, 7'h7F);
    applyStimulus(1'b1, JUNK, 1'b0);
    idleCycles(3, 1'b0);
    applyStimulus(1'b1, 4'h1, 1'b1);
    idleCycles(3, 1'b1);
    applyStimulus(1'b0, 4'h8, 1'b1);
    idleCycles(3, 1'b1);
    idleCycles(1, 1'b0);
    checkOutput("t4b_seg", {1'b0, seg}, 8'h7F);

    // Test 5: reset while a sample is in flight discards it and blanks the display
    applyStimulus(1'b1, JUNK, 1'b0);
    applyStimulus(1'b0, JUNK, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_seg", {1'b0, seg}, 8'h00);
    checkOutput("async_result", {4'd0, result}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'h6, 1'b0);
      checkOutput("post_rst_seg", {1'b0, seg}, 8'h00);
    end
    expectCapture(4'h5, 7'h6D);
    applyStimulus(1'b1, JUNK, 1'b0);
    idleCycles(3, 1'b0);
    applyStimulus(1'b0, 4'h5, 1'b1);
    idleCycles(3, 1'b1);
    idleCycles(1, 1'b0);
    checkOutput("t5_seg", {1'b0, seg}, 8'h6D);

    // Test 6: LATENCY=1, HOLD_CYCLES=1 instance
    in_valid_b = 1'b1; sqrt_q_b = JUNK;
    @(posedge clk); @(negedge clk);
    checkOutput("b_ov0", {7'd0, out_valid_b}, 8'h00);
    checkOutput("b_dp0", {7'd0, dp_b}, 8'h00);
    in_valid_b = 1'b0; sqrt_q_b = 4'hF;
    @(posedge clk); @(negedge clk);
    checkOutput("b_ov1", {7'd0, out_valid_b}, 8'h01);
    checkOutput("b_result1", {4'd0, result_b}, 8'h0F);
    checkOutput("b_seg1", {1'b0, seg_b}, 8'h71);
    checkOutput("b_dp1", {7'd0, dp_b}, 8'h01);
    sqrt_q_b = JUNK;
    @(posedge clk); @(negedge clk);
    checkOutput("b_ov2", {7'd0, out_valid_b}, 8'h00);
    checkOutput("b_dp2", {7'd0, dp_b}, 8'h00);
    checkOutput("b_seg2", {1'b0, seg_b}, 8'h71);

    idleCycles(2, 1'b0);
    checkOutput("scoreboard_empty", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
